// File: rtl/char_lcd_pkg.sv
// rtl/char_lcd_pkg.sv - command classes, DDRAM map constants and FSM states for char_lcd_rcv
package char_lcd_pkg;

    localparam logic [7:0] SPACE_CHAR_DEFAULT = 8'h20;
    localparam logic [6:0] LINE1_BASE         = 7'h00;
    localparam logic [6:0] LINE2_BASE         = 7'h40;
    localparam logic [6:0] LINE_LAST          = 7'h27;

    typedef enum logic [2:0] {
        CMD_CLEAR,
        CMD_HOME,
        CMD_ENTRY,
        CMD_DISP,
        CMD_SHIFT,
        CMD_FUNC,
        CMD_CGRAM,
        CMD_DDRAM
    } cmd_class_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    // Class is chosen by the highest set bit; an all-zero byte is a harmless no-op.
    function automatic cmd_class_t cmd_decode(input logic [7:0] db);
        cmd_class_t c;
        c = CMD_FUNC;
        if (db[7])      c = CMD_DDRAM;
        else if (db[6]) c = CMD_CGRAM;
        else if (db[5]) c = CMD_FUNC;
        else if (db[4]) c = CMD_SHIFT;
        else if (db[3]) c = CMD_DISP;
        else if (db[2]) c = CMD_ENTRY;
        else if (db[1]) c = CMD_HOME;
        else if (db[0]) c = CMD_CLEAR;
        return c;
    endfunction

endpackage

// File: rtl/char_lcd_addr_map.sv
// rtl/char_lcd_addr_map.sv - DDRAM address to buffer index, plus 2-line wrap-aware next addresses
module char_lcd_addr_map
    import char_lcd_pkg::*;
(
    input  logic [6:0] addr,
    output logic [4:0] idx,
    output logic       visible,
    output logic [6:0] addr_inc,
    output logic [6:0] addr_dec
);

    logic [5:0] low;
    logic       line2;

    assign low     = addr[5:0];
    assign line2   = addr[6];
    assign visible = (low < 6'h10);
    assign idx     = {line2, addr[3:0]};

    // Out-of-map offsets (above 0x27 within a line) snap to the neighbouring in-map address.
    always_comb begin
        addr_inc = addr + 7'd1;
        if (low >= LINE_LAST[5:0])
            addr_inc = line2 ? LINE1_BASE : LINE2_BASE;

        addr_dec = addr - 7'd1;
        if (low > LINE_LAST[5:0])
            addr_dec = {line2, LINE_LAST[5:0]};
        else if (low == 6'd0)
            addr_dec = {~line2, LINE_LAST[5:0]};
    end

endmodule

// File: rtl/char_lcd_rcv.sv
// rtl/char_lcd_rcv.sv - HD44780-style LCD bus receiver mirroring 2x16 DDRAM; CHAR_LCD_RCV_BUSY_EN adds busy model
module char_lcd_rcv
    import char_lcd_pkg::*;
#(
    parameter int          BUSY_CYC   = 8,
    parameter logic [7:0]  SPACE_CHAR = SPACE_CHAR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] lcd_db,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] ddram_addr,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       busy,
    output logic       cmd_valid,
    output logic       proto_err
);

    logic [7:0] db_q;
    logic       rs_q, rw_q, e_q, e_qq;
    logic       strobe, accept;
    logic       inc_mode;
    logic [4:0] clr_idx;
    logic [7:0] char_buf [32];
    state_t     state_q, state_d;
    cmd_class_t cmd_class;

    logic [4:0] map_idx;
    logic       map_visible;
    logic [6:0] addr_inc, addr_dec;

    char_lcd_addr_map u_addr_map (
        .addr     (ddram_addr),
        .idx      (map_idx),
        .visible  (map_visible),
        .addr_inc (addr_inc),
        .addr_dec (addr_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            db_q <= '0;
            rs_q <= 1'b0;
            rw_q <= 1'b0;
            e_q  <= 1'b0;
            e_qq <= 1'b0;
        end else begin
            db_q <= lcd_db;
            rs_q <= lcd_rs;
            rw_q <= lcd_rw;
            e_q  <= lcd_e;
            e_qq <= e_q;
        end
    end

    assign strobe    = e_qq & ~e_q;
    assign accept    = strobe & ~rw_q & ~busy;
    assign cmd_class = cmd_decode(db_q);

`ifdef CHAR_LCD_RCV_BUSY_EN
    localparam int BUSY_W = $clog2(BUSY_CYC + 1);
    logic [BUSY_W-1:0] busy_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            busy_cnt <= '0;
        else if (accept)
            busy_cnt <= BUSY_W'(BUSY_CYC);
        else if (busy_cnt != '0)
            busy_cnt <= busy_cnt - 1'b1;
    end

    assign busy = (state_q == CLEAR) | (busy_cnt != '0);
`else
    logic unused_busy_cyc;
    assign unused_busy_cyc = (BUSY_CYC == 0);
    assign busy = (state_q == CLEAR);
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !rs_q && cmd_class == CMD_CLEAR) state_d = CLEAR;
            CLEAR:   if (clr_idx == 5'd31) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ddram_addr <= LINE1_BASE;
            inc_mode   <= 1'b1;
            disp_on    <= 1'b0;
            cursor_on  <= 1'b0;
            cmd_valid  <= 1'b0;
            proto_err  <= 1'b0;
            clr_idx    <= '0;
        end else begin
            cmd_valid <= accept;
            proto_err <= strobe & ~accept;
            // clr_idx wraps 31->0 on the last sweep cycle, so it is ready for the next clear.
            if (state_q == CLEAR) clr_idx <= clr_idx + 5'd1;
            if (accept) begin
                if (rs_q) begin
                    ddram_addr <= inc_mode ? addr_inc : addr_dec;
                end else begin
                    case (cmd_class)
                        CMD_CLEAR: begin
                            ddram_addr <= LINE1_BASE;
                            inc_mode   <= 1'b1;
                        end
                        CMD_HOME:  ddram_addr <= LINE1_BASE;
                        CMD_ENTRY: inc_mode <= db_q[1];
                        CMD_DISP: begin
                            disp_on   <= db_q[2];
                            cursor_on <= db_q[1];
                        end
                        CMD_SHIFT: if (!db_q[3]) ddram_addr <= db_q[2] ? addr_inc : addr_dec;
                        CMD_DDRAM: ddram_addr <= db_q[6:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) char_buf[i] <= SPACE_CHAR;
        end else if (state_q == CLEAR) begin
            char_buf[clr_idx] <= SPACE_CHAR;
        end else if (accept && rs_q && map_visible) begin
            char_buf[map_idx] <= db_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_char <= '0;
        else     rd_char <= char_buf[rd_addr];
    end

endmodule

// File: tb/tb_char_lcd_rcv.sv
// tb/tb_char_lcd_rcv.sv - directed and randomized bench for char_lcd_rcv against a behavioural display model
module tb_char_lcd_rcv;

    localparam int BUSY_CYC = 8;
`ifdef CHAR_LCD_RCV_BUSY_EN
    localparam int GAP        = BUSY_CYC;
    localparam bit BUSY_MODEL = 1'b1;
`else
    localparam int GAP        = 0;
    localparam bit BUSY_MODEL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] lcd_db = '0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic       lcd_e = 1'b0;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_char;
    logic [6:0] ddram_addr;
    logic       disp_on, cursor_on, busy, cmd_valid, proto_err;

    char_lcd_rcv #(.BUSY_CYC(BUSY_CYC), .SPACE_CHAR(8'h20)) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_db     (lcd_db),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .rd_addr    (rd_addr),
        .rd_char    (rd_char),
        .ddram_addr (ddram_addr),
        .disp_on    (disp_on),
        .cursor_on  (cursor_on),
        .busy       (busy),
        .cmd_valid  (cmd_valid),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Display model: visible characters, address counter, mode bits and the last busy cycle.
    byte unsigned mbuf [32];
    int  maddr;
    bit  minc, mdisp, mcur;
    int  busy_end;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        maddr = 0; minc = 1; mdisp = 0; mcur = 0; busy_end = -1;
    endtask

    function automatic int next_addr(input int a, input bit up);
        if (up) begin
            if (a < 'h40) return (a >= 'h27) ? 'h40 : a + 1;
            return (a >= 'h67) ? 'h00 : a + 1;
        end
        if (a == 'h00) return 'h67;
        if (a == 'h40) return 'h27;
        if (a > 'h27 && a < 'h40) return 'h27;
        if (a > 'h67) return 'h67;
        return a - 1;
    endfunction

    // Applies one strobe whose action lands on cycle 'now'; returns whether it is accepted.
    function automatic bit model_apply(input bit rs, input bit rw, input int db, input int now);
        int hold;
        if (rw || (now - 1) <= busy_end) return 1'b0;
        hold = BUSY_MODEL ? BUSY_CYC : 0;
        if (rs) begin
            if (maddr < 'h10) mbuf[maddr] = 8'(db);
            else if (maddr >= 'h40 && maddr < 'h50) mbuf[maddr - 'h30] = 8'(db);
            maddr = next_addr(maddr, minc);
        end else if (db >= 'h80) maddr = db - 'h80;
        else if (db >= 'h20) begin end
        else if (db >= 'h10) begin
            if ((db & 8) == 0) maddr = next_addr(maddr, (db & 4) != 0);
        end
        else if (db >= 'h08) begin mdisp = (db & 4) != 0; mcur = (db & 2) != 0; end
        else if (db >= 'h04) minc = (db & 2) != 0;
        else if (db >= 'h02) maddr = 0;
        else if (db == 'h01) begin
            for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
            maddr = 0; minc = 1;
            hold = (hold > 32) ? hold : 32;
        end
        if (hold > 0) busy_end = now + hold - 1;
        return 1'b1;
    endfunction

    task automatic do_strobe(input bit rs, input bit rw, input logic [7:0] db);
        bit acc;
        repeat (GAP) @(posedge clk);
        #1;
        lcd_db = db; lcd_rs = rs; lcd_rw = rw; lcd_e = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        lcd_e = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        acc = model_apply(rs, rw, int'(db), cyc);
        check($sformatf("cmd_valid rs%0d rw%0d db%02h", rs, rw, db), int'(cmd_valid), int'(acc));
        check($sformatf("proto_err rs%0d rw%0d db%02h", rs, rw, db), int'(proto_err), int'(!acc));
        check($sformatf("ddram_addr db%02h", db), int'(ddram_addr), maddr);
        check("disp_on", int'(disp_on), int'(mdisp));
        check("cursor_on", int'(cursor_on), int'(mcur));
        check("busy", int'(busy), int'(cyc <= busy_end));
    endtask

    task automatic check_buf(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            @(posedge clk); #1;
            check($sformatf("%s[%0d]", tag, i), int'(rd_char), int'(mbuf[i]));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle", int'(busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst rd_char", int'(rd_char), 0);
        check("rst busy", int'(busy), 0);
        check("rst cmd_valid", int'(cmd_valid), 0);
        check("rst proto_err", int'(proto_err), 0);
        check("rst disp_on", int'(disp_on), 0);
        check("rst cursor_on", int'(cursor_on), 0);
        check("rst ddram_addr", int'(ddram_addr), 0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int n;
        model_reset();
        do_reset();
        check_buf("reset_buf");

        do_strobe(0, 0, 8'h38);
        do_strobe(0, 0, 8'h08);
        do_strobe(0, 0, 8'h01);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("clear_busy_cycles", n, 32);
        busy_end = -1;
        do_strobe(0, 0, 8'h06);
        do_strobe(0, 0, 8'h0C);
        do_strobe(1, 0, 8'h48);
        do_strobe(1, 0, 8'h49);
        check("hi ddram_addr", int'(ddram_addr), 2);
        check("hi disp_on", int'(disp_on), 1);
        check_buf("hi_buf");
        check("hi model[0]", int'(mbuf[0]), 'h48);

        do_strobe(0, 0, 8'hC0);
        for (int i = 0; i < 16; i++) do_strobe(1, 0, 8'(8'h41 + i));
        check("line2 ddram_addr", int'(ddram_addr), 'h50);
        check_buf("line2_buf");

        do_strobe(0, 0, 8'hA7);
        check("wrap a7", int'(ddram_addr), 'h27);
        do_strobe(1, 0, 8'h5A);
        check("wrap inc", int'(ddram_addr), 'h40);
        do_strobe(0, 0, 8'h04);
        do_strobe(1, 0, 8'h33);
        check("wrap dec", int'(ddram_addr), 'h27);
        do_strobe(1, 0, 8'h34);
        check("dec 26", int'(ddram_addr), 'h26);
        check_buf("wrap_buf");
        do_strobe(0, 0, 8'h06);

        do_strobe(0, 0, 8'h01);
        do_strobe(1, 0, 8'h55);
        wait_idle();
        busy_end = -1;
        do_strobe(1, 1, 8'h66);
        check_buf("drop_buf");

        do_strobe(0, 0, 8'h80);
        do_strobe(1, 0, 8'h77);
        do_strobe(0, 0, 8'h01);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midclear busy", int'(busy), 0);
        rst = 1'b0;
        model_reset();
        check_buf("midclear_buf");

        for (int k = 0; k < 150; k++) begin
            bit         rs, rw;
            logic [7:0] db;
            rs = 1'($urandom_range(0, 1));
            rw = ($urandom_range(0, 9) == 0);
            db = 8'($urandom);
            if (!rs && $urandom_range(0, 15) == 0) db = 8'h01;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_strobe(rs, rw, db);
        end
        wait_idle();
        check_buf("rand_buf");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
